// File: rtl/audio_sd_dac.sv
// audio_sd_dac
// Per-channel audio DAC front end: resamples a quasi-static unsigned sample
// once per SAMPLE_DIV clocks, linearly interpolates from the previous sample
// towards the new one in 2^INTERP_K steps, and drives a second-order
// delta-sigma modulator whose 1-bit output feeds the board RC filter.
//
// Ports
//   clk_sys     in   system clock, all logic on rising edge
//   reset       in   synchronous active-high reset
//   audio_in    in   IN_W-bit unsigned sample, sampled only at the strobe
//   sample_stb  out  one-cycle pulse coinciding with the capture edge
//   interp_out  out  IN_W+INTERP_K-bit interpolated value (debug)
//   dac_out     out  delta-sigma bitstream
//
// SAMPLE_DIV must be a multiple of 2^INTERP_K so each interpolation step
// lasts a whole number of clocks and the last step ends on the strobe.
module audio_sd_dac #(
    parameter int IN_W       = 6,
    parameter int INTERP_K   = 4,
    parameter int SAMPLE_DIV = 448
) (
    input  logic                         clk_sys,
    input  logic                         reset,
    input  logic [IN_W-1:0]              audio_in,
    output logic                         sample_stb,
    output logic [IN_W+INTERP_K-1:0]     interp_out,
    output logic                         dac_out
);

    localparam int W      = IN_W + INTERP_K;
    localparam int DIV_W  = $clog2(SAMPLE_DIV);
    localparam int STEP_N = SAMPLE_DIV >> INTERP_K;
    localparam int STEP_W = (STEP_N > 1) ? $clog2(STEP_N) : 1;
    localparam int PW     = W + 2;   // interpolator arithmetic width (signed)
    localparam int SW     = W + 4;   // modulator integrator width
    localparam int EW     = W + 6;   // headroom for integrator sums before clamp

    localparam logic signed [EW-1:0] HALF_E = EW'(2 ** (W - 1));
    localparam logic signed [EW-1:0] LIM_E  = EW'(2 ** (W + 2) - 1);
    localparam logic signed [EW-1:0] NLIM_E = -LIM_E;

    // Sample divider / interpolator state
    logic [DIV_W-1:0]        div_cnt_q;
    logic [STEP_W-1:0]       step_cnt_q;
    logic [INTERP_K-1:0]     phase_q;
    logic [IN_W-1:0]         prev_q;
    logic [IN_W-1:0]         held_q;
    logic signed [IN_W:0]    delta_q;
    logic                    sample_stb_q;
    logic [W-1:0]            interp_q;

    // Modulator state
    logic signed [SW-1:0]    i1_q;
    logic signed [SW-1:0]    i2_q;
    logic                    dac_q;

    // Next-state values
    logic                    last_d;
    logic                    step_wrap_d;
    logic signed [IN_W:0]    delta_d;
    logic [W-1:0]            interp_d;
    logic signed [SW-1:0]    i1_d;
    logic signed [SW-1:0]    i2_d;
    logic                    dac_d;

    logic signed [PW-1:0]    held_ext;
    logic signed [PW-1:0]    delta_ext;
    logic signed [PW-1:0]    phase_ext;
    logic signed [PW-1:0]    interp_sum;
    logic signed [EW-1:0]    xs;
    logic signed [EW-1:0]    fb;
    logic signed [EW-1:0]    i1_sum;
    logic signed [EW-1:0]    i2_sum;

    function automatic logic signed [SW-1:0] sat(input logic signed [EW-1:0] v);
        logic signed [SW-1:0] r;
        if (v > LIM_E) begin
            r = LIM_E[SW-1:0];
        end else if (v < NLIM_E) begin
            r = NLIM_E[SW-1:0];
        end else begin
            r = v[SW-1:0];
        end
        return r;
    endfunction

    always_comb begin
        last_d      = (div_cnt_q == DIV_W'(SAMPLE_DIV - 1));
        step_wrap_d = (step_cnt_q == STEP_W'(STEP_N - 1));
        delta_d     = $signed({1'b0, audio_in}) - $signed({1'b0, prev_q});

        // held*2^K + delta*phase; the ramp never leaves [0, (2^IN_W-1)<<K]
        // so the truncation back to W bits is lossless.
        held_ext   = $signed(PW'(held_q)) <<< INTERP_K;
        delta_ext  = PW'(delta_q);
        phase_ext  = $signed(PW'(phase_q));
        interp_sum = held_ext + delta_ext * phase_ext;
        interp_d   = interp_sum[W-1:0];

        // Modulator input is centred on mid-scale; feedback is +-half-scale.
        xs     = $signed(EW'(interp_q)) - HALF_E;
        fb     = dac_q ? HALF_E : -HALF_E;
        i1_sum = EW'(i1_q) + xs - fb;
        // Second integrator takes the registered first-integrator value.
        i2_sum = EW'(i2_q) + EW'(i1_q) - fb;
        i1_d   = sat(i1_sum);
        i2_d   = sat(i2_sum);
        dac_d  = ~i2_d[SW-1];
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            div_cnt_q    <= '0;
            step_cnt_q   <= '0;
            phase_q      <= '0;
            prev_q       <= '0;
            held_q       <= '0;
            delta_q      <= '0;
            sample_stb_q <= 1'b0;
            interp_q     <= '0;
            i1_q         <= '0;
            i2_q         <= '0;
            dac_q        <= 1'b0;
        end else begin
            div_cnt_q    <= last_d ? '0 : div_cnt_q + DIV_W'(1);
            sample_stb_q <= last_d;
            if (last_d) begin
                prev_q     <= audio_in;
                held_q     <= prev_q;
                delta_q    <= delta_d;
                phase_q    <= '0;
                step_cnt_q <= '0;
            end else if (step_wrap_d) begin
                step_cnt_q <= '0;
                if (phase_q != {INTERP_K{1'b1}}) begin
                    phase_q <= phase_q + INTERP_K'(1);
                end
            end else begin
                step_cnt_q <= step_cnt_q + STEP_W'(1);
            end
            interp_q <= interp_d;
            i1_q     <= i1_d;
            i2_q     <= i2_d;
            dac_q    <= dac_d;
        end
    end

    assign sample_stb = sample_stb_q;
    assign interp_out = interp_q;
    assign dac_out    = dac_q;

endmodule

// File: tb/tb_audio_sd_dac.sv
// Testbench for audio_sd_dac: directed vectors with hand-computed expected
// values, steady-level density windows, plus a cycle-level reference model of
// the divider, interpolator and modulator compared on every falling edge.
module tb_audio_sd_dac;

    localparam int SD   = 448;
    localparam int STEP = 28;
    localparam int LIM  = 4095;

    logic       clk_sys  = 1'b0;
    logic       reset    = 1'b1;
    logic [5:0] audio_in = 6'd32;
    logic       sample_stb;
    logic [9:0] interp_out;
    logic       dac_out;

    always #5 clk_sys = ~clk_sys;

    audio_sd_dac dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .audio_in   (audio_in),
        .sample_stb (sample_stb),
        .interp_out (interp_out),
        .dac_out    (dac_out)
    );

    int tests  = 0;
    int failed = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end else begin
            $display("[TB] ok %s value=%0d", name, act);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            failed++;
            $display("[TB] FAIL %s actual=%0d expected=[%0d,%0d]", name, act, lo, hi);
        end else begin
            $display("[TB] ok %s value=%0d in [%0d,%0d]", name, act, lo, hi);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int msat(input int v);
        if (v > LIM) return LIM;
        if (v < -LIM) return -LIM;
        return v;
    endfunction

    function automatic int mfb(input int d);
        return (d != 0) ? 512 : -512;
    endfunction

    int m_div, m_step, m_phase, m_prev, m_held, m_delta;
    int m_stb, m_interp, m_i1, m_i2, m_dac;

    always @(posedge clk_sys) begin
        if (reset) begin
            m_div <= 0; m_step <= 0; m_phase <= 0; m_prev <= 0; m_held <= 0;
            m_delta <= 0; m_stb <= 0; m_interp <= 0; m_i1 <= 0; m_i2 <= 0; m_dac <= 0;
        end else begin
            m_i1     <= msat(m_i1 + (m_interp - 512) - mfb(m_dac));
            m_i2     <= msat(m_i2 + m_i1 - mfb(m_dac));
            m_dac    <= (msat(m_i2 + m_i1 - mfb(m_dac)) >= 0) ? 1 : 0;
            m_interp <= m_held * 16 + m_delta * m_phase;
            if (m_div == SD - 1) begin
                m_div   <= 0;
                m_stb   <= 1;
                m_held  <= m_prev;
                m_delta <= int'(audio_in) - m_prev;
                m_prev  <= int'(audio_in);
                m_phase <= 0;
                m_step  <= 0;
            end else begin
                m_div <= m_div + 1;
                m_stb <= 0;
                if (m_step == STEP - 1) begin
                    m_step <= 0;
                    if (m_phase < 15) m_phase <= m_phase + 1;
                end else begin
                    m_step <= m_step + 1;
                end
            end
        end
    end

    bit cmp_en  = 1'b0;
    int mism    = 0;
    int max_abs = 0;

    always @(negedge clk_sys) begin
        int a1, a2;
        if (cmp_en) begin
            if (sample_stb !== m_stb[0] || interp_out !== 10'(m_interp) || dac_out !== m_dac[0])
                mism++;
            a1 = int'(dut.i1_q);
            a2 = int'(dut.i2_q);
            if (a1 < 0) a1 = -a1;
            if (a2 < 0) a2 = -a2;
            if (a1 > max_abs) max_abs = a1;
            if (a2 > max_abs) max_abs = a2;
        end
    end

    // ---------------- helpers ----------------
    task automatic count_to_stb(output int n);
        n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (!sample_stb && n < 2000);
    endtask

    task automatic wait_stb();
        int n;
        count_to_stb(n);
        check("stb_seen", int'(sample_stb), 1);
    endtask

    task automatic cycles(input int k);
        repeat (k) @(negedge clk_sys);
    endtask

    task automatic count_ones(input int k, output int ones);
        ones = 0;
        repeat (k) begin
            @(negedge clk_sys);
            ones += int'(dac_out);
        end
    endtask

    typedef struct {
        int audio;
        int exp_interp;
        int dmin;
        int dmax;
    } level_t;

    typedef struct {
        int n;
        int exp_interp;
    } ramp_t;

    level_t levels[3];
    ramp_t  ramp[33];

    initial begin
        int n, ones, cur;

        levels[0] = '{32, 512, 4055, 4137};
        levels[1] = '{63, 1008, 7979, 8143};
        levels[2] = '{0, 0, 0, 81};
        for (int p = 0; p < 16; p++) begin
            ramp[2*p]     = '{STEP*p + 1, 32*p};
            ramp[2*p + 1] = '{STEP*p + STEP, 32*p};
        end
        ramp[32] = '{SD + 1, 512};

        // Reset held for 5 cycles
        reset = 1'b1;
        cycles(5);
        check("rst_stb", int'(sample_stb), 0);
        check("rst_interp", int'(interp_out), 0);
        check("rst_dac", int'(dac_out), 0);
        check("rst_i1", int'(dut.i1_q), 0);
        check("rst_i2", int'(dut.i2_q), 0);
        reset  = 1'b0;
        cmp_en = 1'b1;

        count_to_stb(n);
        check("first_stb_latency", n, SD);
        count_to_stb(n);
        check("stb_period", n, SD);

        // Steady levels: interp value and ones density
        for (int i = 0; i < 3; i++) begin
            audio_in = 6'(levels[i].audio);
            wait_stb();
            wait_stb();
            cycles(2);
            check($sformatf("level%0d_interp", levels[i].audio), int'(interp_out), levels[i].exp_interp);
            count_ones(8192, ones);
            check_range($sformatf("level%0d_density", levels[i].audio), ones, levels[i].dmin, levels[i].dmax);
            check("model_match", mism, 0);
            if (i == 1) check_range("integrator_bound", max_abs, 0, LIM);
        end

        // Step 0 -> 32: ramp walks 0,32,...,480 then 512
        wait_stb();
        audio_in = 6'd32;
        wait_stb();
        cur = 0;
        for (int i = 0; i < 33; i++) begin
            cycles(ramp[i].n - cur);
            cur = ramp[i].n;
            check($sformatf("ramp_n%0d", ramp[i].n), int'(interp_out), ramp[i].exp_interp);
        end

        // Recovery from zero input back to mid-scale
        cycles(SD);
        count_ones(8192, ones);
        check_range("recover_density", ones, 4055, 4137);
        check_range("integrator_bound_all", max_abs, 0, LIM);

        // audio_in toggles between strobes; only the strobe-cycle value counts
        wait_stb();
        for (int k = 0; k < SD - 1; k++) begin
            audio_in = ((k / 10) % 2 != 0) ? 6'd63 : 6'd5;
            @(negedge clk_sys);
        end
        audio_in = 6'd20;
        @(negedge clk_sys);
        check("toggle_stb", int'(sample_stb), 1);
        for (int k = 1; k <= SD + 1; k++) begin
            @(negedge clk_sys);
            if (k == 1)        check("toggle_n1", int'(interp_out), 512);
            if (k == STEP + 1) check("toggle_n29", int'(interp_out), 500);
            if (k == 421)      check("toggle_n421", int'(interp_out), 332);
            if (k == SD)       check("toggle_stb2", int'(sample_stb), 1);
            if (k == SD + 1)   check("toggle_final", int'(interp_out), 320);
            audio_in = (k >= SD - 1) ? 6'd20 : (((k / 10) % 2 != 0) ? 6'd0 : 6'd63);
        end
        check("model_match_toggle", mism, 0);

        // One-cycle reset in the middle of a ramp
        audio_in = 6'd50;
        wait_stb();
        cycles(100);
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        check("midrst_stb", int'(sample_stb), 0);
        check("midrst_interp", int'(interp_out), 0);
        check("midrst_dac", int'(dac_out), 0);
        check("midrst_i1", int'(dut.i1_q), 0);
        check("midrst_i2", int'(dut.i2_q), 0);
        count_to_stb(n);
        check("midrst_stb_latency", n, SD);
        cycles(1);
        check("midrst_held0", int'(interp_out), 0);
        cycles(STEP);
        check("midrst_step1", int'(interp_out), 50);
        check("model_match_final", mism, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
